// File: rtl/token_score_sorter_if.sv
// Token score sorter bus.
//   Input side : in_valid / in_score from the producer, in_ready back from the sorter.
//   Output side: sort_en / sort_res / sort_index / sort_done from the sorter,
//                out_ready back from the consumer.
// Handshake: a transfer happens on a rising clock edge where valid (in_valid or
// sort_en) and ready (in_ready or out_ready) are both 1. While valid=1 and
// ready=0 the source holds its payload stable. Valid never waits on ready.
// in_ready depends only on sorter state. Input presented while in_ready=0 is
// dropped, not queued.
// Modports: master = producer/consumer side, slave = sorter side.
interface token_score_sorter_if #(
  parameter int score_w = 32,
  parameter int idx_w   = 16
);
  logic               in_valid;
  logic [score_w-1:0] in_score;
  logic               in_ready;
  logic               out_ready;
  logic               sort_en;
  logic [score_w-1:0] sort_res;
  logic [idx_w-1:0]   sort_index;
  logic               sort_done;

  modport master (
    output in_valid, in_score, out_ready,
    input  in_ready, sort_en, sort_res, sort_index, sort_done
  );

  modport slave (
    input  in_valid, in_score, out_ready,
    output in_ready, sort_en, sort_res, sort_index, sort_done
  );
endinterface

// File: rtl/token_score_sorter.sv
// token_score_sorter: gathers dimen token scores per frame and streams them
// back highest score first. Ties keep arrival order (lower index first).
// Each accepted score is insertion-sorted into a register array in the accept
// cycle. Output is one entry per cycle under out_ready backpressure.
// Ports:
//   CLK          clock, rising edge
//   RESET        synchronous active-high reset
//   bus          token_score_sorter_if.slave (in_valid/in_score/in_ready,
//                out_ready/sort_en/sort_res/sort_index/sort_done)
//   dbg_state_o  current FSM state (0=LOAD, 1=EMIT, 2=DONE)
module token_score_sorter #(
  parameter int dimen     = 16,
  parameter int cnt_width = 4,
  parameter int score_w   = 32,
  parameter int idx_w     = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  token_score_sorter_if.slave  bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [cnt_width:0] LAST_CNT = (cnt_width+1)'(dimen-1);

  state_e             state_q;
  logic [cnt_width:0] wr_cnt_q;
  logic [cnt_width:0] rd_ptr_q;
  logic [score_w-1:0] score_q [dimen];
  logic [idx_w-1:0]   idx_q   [dimen];
  logic [dimen-1:0]   vld_q;
  logic [score_w-1:0] score_d [dimen];
  logic [idx_w-1:0]   idx_d   [dimen];
  logic [dimen-1:0]   vld_d;
  logic [dimen-1:0]   ge;

  logic               sort_en_q;
  logic [score_w-1:0] sort_res_q;
  logic [idx_w-1:0]   sort_index_q;
  logic               sort_done_q;

  logic               accept;
  logic [cnt_width:0] wr_cnt_inc;
  logic [idx_w-1:0]   new_idx;
  logic [cnt_width-1:0] rd_nxt;

  assign accept     = (state_q == ST_LOAD) && bus.in_valid;
  assign wr_cnt_inc = wr_cnt_q + 1'b1;
  assign new_idx    = idx_w'(wr_cnt_inc);
  assign rd_nxt     = rd_ptr_q[cnt_width-1:0] + 1'b1;

  // The array stays sorted descending with valid slots packed at the front,
  // so ge[] is a prefix mask. The first slot with ge=0 is the insert point
  // and every later slot takes its upper neighbour. Using >= keeps equal
  // scores that arrived earlier ahead of the newcomer.
  always_comb begin
    for (int i = 0; i < dimen; i++) begin
      ge[i]      = vld_q[i] && (score_q[i] >= bus.in_score);
      score_d[i] = score_q[i];
      idx_d[i]   = idx_q[i];
      vld_d[i]   = vld_q[i];
    end
    if (accept) begin
      if (!ge[0]) begin
        score_d[0] = bus.in_score;
        idx_d[0]   = new_idx;
        vld_d[0]   = 1'b1;
      end
      for (int i = 1; i < dimen; i++) begin
        if (!ge[i]) begin
          if (ge[i-1]) begin
            score_d[i] = bus.in_score;
            idx_d[i]   = new_idx;
            vld_d[i]   = 1'b1;
          end else begin
            score_d[i] = score_q[i-1];
            idx_d[i]   = idx_q[i-1];
            vld_d[i]   = vld_q[i-1];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_LOAD;
      wr_cnt_q     <= '0;
      rd_ptr_q     <= '0;
      vld_q        <= '0;
      for (int i = 0; i < dimen; i++) begin
        score_q[i] <= '0;
        idx_q[i]   <= '0;
      end
      sort_en_q    <= 1'b0;
      sort_res_q   <= '0;
      sort_index_q <= '0;
      sort_done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          score_q <= score_d;
          idx_q   <= idx_d;
          vld_q   <= vld_d;
          if (accept) begin
            wr_cnt_q <= wr_cnt_inc;
            if (wr_cnt_q == LAST_CNT) begin
              // Head of the array after this final insert becomes the
              // first output, so it is taken from the next-state view.
              state_q      <= ST_EMIT;
              sort_en_q    <= 1'b1;
              sort_res_q   <= score_d[0];
              sort_index_q <= idx_d[0];
            end
          end
        end
        ST_EMIT: begin
          if (bus.out_ready) begin
            if (rd_ptr_q == LAST_CNT) begin
              state_q      <= ST_DONE;
              sort_en_q    <= 1'b0;
              sort_res_q   <= '0;
              sort_index_q <= '0;
              sort_done_q  <= 1'b1;
            end else begin
              rd_ptr_q     <= rd_ptr_q + 1'b1;
              sort_res_q   <= score_q[rd_nxt];
              sort_index_q <= idx_q[rd_nxt];
            end
          end
        end
        ST_DONE: begin
          state_q     <= ST_LOAD;
          sort_done_q <= 1'b0;
          vld_q       <= '0;
          wr_cnt_q    <= '0;
          rd_ptr_q    <= '0;
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == ST_LOAD);
  assign bus.sort_en    = sort_en_q;
  assign bus.sort_res   = sort_res_q;
  assign bus.sort_index = sort_index_q;
  assign bus.sort_done  = sort_done_q;
  assign dbg_state_o    = state_q;

endmodule
